// File: rtl/timer_peripheral_if.sv
// CPU-side bus bundle for timer_peripheral.
//   R_W_n    : CPU read/write strobe, 0 = write
//   timer_cs : chip select from the address decoder
//   addr_i   : live CPU address, [2:0] selects the write register
//   addr_w_i : registered CPU address, [2:0] selects the read register
//   data_i   : CPU write data
//   data_o   : read data, 8'h00 when not selected
//   irq_o    : level interrupt request, active-high
interface timer_peripheral_if;
  logic        R_W_n;
  logic        timer_cs;
  logic [15:0] addr_i;
  logic [15:0] addr_w_i;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        irq_o;

  modport master (
    output R_W_n, timer_cs, addr_i, addr_w_i, data_i,
    input  data_o, irq_o
  );

  modport slave (
    input  R_W_n, timer_cs, addr_i, addr_w_i, data_i,
    output data_o, irq_o
  );
endinterface

// File: rtl/timer_peripheral.sv
// Prescaled 16-bit down-counting timer with auto-reload, one-shot mode,
// coherent snapshot register and an expiry flag with optional interrupt.
//
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : timer_peripheral_if.slave (register read/write, irq_o)
//
// Build option: define TIMER_IRQ_EN to make CTRL.IE writable and drive
// irq_o = EXP & IE. Without it irq_o is tied low and IE reads 0.
//
// State table:
//   IDLE | counter and prescaler frozen, COUNT holds its value
//   RUN  | prescaler running, COUNT decrements on each tick
module timer_peripheral #(
  parameter logic [7:0] RESET_PRESCALE = 8'd49
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  timer_peripheral_if.slave  bus
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_RELOAD_L = 3'd2;
  localparam logic [2:0] OFF_RELOAD_H = 3'd3;
  localparam logic [2:0] OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic        ctrl_en;
  logic        ctrl_auto;
  logic        ctrl_ie;
  logic        exp_flag;
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] snap;
  logic [7:0]  prescale;
  logic [7:0]  presc_cnt;

  logic        wr;
  logic [2:0]  wr_sel;
  logic        tick;
  logic        expire;
  logic        unused_addr;

  assign wr     = bus.timer_cs & ~bus.R_W_n;
  assign wr_sel = bus.addr_i[2:0];
  assign tick   = (state == RUN) && (presc_cnt == prescale);
  assign expire = tick && (count == 16'd0);

  // Upper address bits are already decoded into timer_cs.
  assign unused_addr = ^{bus.addr_i[15:3], bus.addr_w_i[15:3]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      exp_flag  <= 1'b0;
      reload    <= 16'hFFFF;
      count     <= 16'd0;
      snap      <= 16'd0;
      prescale  <= RESET_PRESCALE;
      presc_cnt <= 8'd0;
    end else begin
      // Timebase; a CPU write further down overrides any field it touches.
      if (state == RUN) begin
        if (tick) begin
          presc_cnt <= 8'd0;
          if (count == 16'd0) begin
            exp_flag <= 1'b1;
            count    <= reload;
            if (!ctrl_auto) begin
              ctrl_en <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            count <= count - 16'd1;
          end
        end else begin
          presc_cnt <= presc_cnt + 8'd1;
        end
      end

      if (wr) begin
        case (wr_sel)
          OFF_CTRL: begin
            ctrl_en   <= bus.data_i[0];
            ctrl_auto <= bus.data_i[1];
`ifdef TIMER_IRQ_EN
            ctrl_ie   <= bus.data_i[2];
`endif
            if (!bus.data_i[0]) begin
              state <= IDLE;
            end else if (state == IDLE) begin
              state     <= RUN;
              count     <= reload;
              presc_cnt <= 8'd0;
            end else begin
              // Already running: keep COUNT/prescaler, and cancel a
              // coincident one-shot stop since the written EN wins.
              state <= RUN;
            end
          end
          OFF_STATUS: begin
            // A coincident expiry keeps the flag set.
            if (bus.data_i[0] && !expire) exp_flag <= 1'b0;
          end
          OFF_RELOAD_L: reload[7:0]  <= bus.data_i;
          OFF_RELOAD_H: reload[15:8] <= bus.data_i;
          OFF_SNAP_L:   snap         <= count;
          OFF_PRESCALE: prescale     <= bus.data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.data_o = 8'h00;
    if (bus.timer_cs) begin
      case (bus.addr_w_i[2:0])
        OFF_CTRL:     bus.data_o = {5'b0, ctrl_ie, ctrl_auto, ctrl_en};
        OFF_STATUS:   bus.data_o = {6'b0, (state == RUN), exp_flag};
        OFF_RELOAD_L: bus.data_o = reload[7:0];
        OFF_RELOAD_H: bus.data_o = reload[15:8];
        OFF_SNAP_L:   bus.data_o = snap[7:0];
        OFF_SNAP_H:   bus.data_o = snap[15:8];
        OFF_PRESCALE: bus.data_o = prescale;
        default:      bus.data_o = 8'h00;
      endcase
    end
  end

`ifdef TIMER_IRQ_EN
  assign bus.irq_o = exp_flag & ctrl_ie;
`else
  assign bus.irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_timer_peripheral.sv
`timescale 1ns/1ps
module tb_timer_peripheral;
  localparam logic [7:0] RP = 8'd49;
`ifdef TIMER_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif
  localparam logic [7:0] CTRL_MASK = IRQ_BUILD ? 8'h07 : 8'h03;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  timer_peripheral_if bus();

  timer_peripheral #(.RESET_PRESCALE(RP)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write is taken on the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    bus.addr_i   = 16'hFE00 | {13'd0, off};
    bus.data_i   = d;
    bus.R_W_n    = 1'b0;
    bus.timer_cs = 1'b1;
    @(posedge clk);
    #1;
    bus.timer_cs = 1'b0;
    bus.R_W_n    = 1'b1;
  endtask

  // Combinational read through a mirrored address.
  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    bus.addr_w_i = 16'hFE10 | {13'd0, off};
    bus.R_W_n    = 1'b1;
    bus.timer_cs = 1'b1;
    #1;
    d = bus.data_o;
    bus.timer_cs = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] tbl [8];
    logic [7:0] got, want;
    tbl = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, RP, 8'h00};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i]);
      rd(i[2:0], got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got %h want %h", i, got, want);
      end
    end
    vectors++;
    if (bus.irq_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b want 0", bus.irq_o);
    end
    bus.addr_w_i = 16'hFE06;
    bus.timer_cs = 1'b0;
    #1;
    vectors++;
    if (bus.data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL deselected_read: got %h want 00", bus.data_o);
    end
  endtask

  task automatic test_auto_reload;
    logic [7:0] got, want;
    logic exp_m = 1'b0;
    logic set, clr;
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h07);
    exp_q.push_back(8'h07 & CTRL_MASK);
    rd(3'd0, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL auto_ctrl: got %h want %h", got, want);
    end
    // Edges 5, 12, 13 after the CTRL write carry a STATUS W1C.
    for (int k = 1; k <= 13; k++) begin
      clr = (k == 5 || k == 12 || k == 13);
      set = (k % 4 == 0);
      if (clr) wr(3'd1, 8'h01);
      else tick(1);
      if (clr && !set) exp_m = 1'b0;
      if (set) exp_m = 1'b1;
      exp_q.push_back({6'b0, 1'b1, exp_m});
      rd(3'd1, got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL auto_status[%0d]: got %h want %h", k, got, want);
      end
      vectors++;
      if (bus.irq_o !== (exp_m & IRQ_BUILD)) begin
        miscompares++;
        $display("FAIL auto_irq[%0d]: got %b want %b", k, bus.irq_o, exp_m & IRQ_BUILD);
      end
    end
    wr(3'd0, 8'h00);
    exp_q.push_back(8'h00);
    rd(3'd1, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL auto_stop_status: got %h want %h", got, want);
    end
  endtask

  task automatic test_one_shot;
    logic [7:0] got, want;
    wr(3'd6, 8'h04);
    wr(3'd2, 8'h02);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h01);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      exp_q.push_back((k < 15) ? 8'h02 : 8'h01);
      rd(3'd1, got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL oneshot_status[%0d]: got %h want %h", k, got, want);
      end
    end
    exp_q.push_back(8'h00);
    rd(3'd0, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL oneshot_ctrl: got %h want %h", got, want);
    end
    wr(3'd4, 8'h5A);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    for (int i = 4; i <= 5; i++) begin
      rd(i[2:0], got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL oneshot_count[%0d]: got %h want %h", i, got, want);
      end
    end
    wr(3'd1, 8'h01);
    tick(20);
    exp_q.push_back(8'h00);
    rd(3'd1, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL oneshot_no_rearm: got %h want %h", got, want);
    end
  endtask

  task automatic test_snapshot;
    logic [7:0] got, want;
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    wr(3'd0, 8'h01);
    tick(8'h80);
    wr(3'd4, 8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h00);
      for (int i = 4; i <= 5; i++) begin
        rd(i[2:0], got);
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL snap_hold[%0d/%0d]: got %h want %h", pass, i, got, want);
        end
      end
      if (pass == 0) tick(10);
    end
    wr(3'd4, 8'h00);
    exp_q.push_back(8'h75);
    exp_q.push_back(8'h00);
    for (int i = 4; i <= 5; i++) begin
      rd(i[2:0], got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL snap_second[%0d]: got %h want %h", i, got, want);
      end
    end
    wr(3'd0, 8'h00);
  endtask

  task automatic test_ctrl_collision;
    logic [7:0] got, want;
    wr(3'd1, 8'h01);
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h01);
    tick(1);
    wr(3'd0, 8'h03);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h03);
    for (int i = 0; i <= 1; i++) begin
      rd(i[2:0], got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL collide[%0d]: got %h want %h", i, got, want);
      end
    end
    wr(3'd1, 8'h01);
    tick(1);
    exp_q.push_back(8'h03);
    rd(3'd1, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL collide_rerun: got %h want %h", got, want);
    end
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] tbl [8];
    logic [7:0] got, want;
    tbl = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, RP, 8'h00};
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h07);
    tick(2);
    #4 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i]);
      rd(i[2:0], got);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL midrun_read[%0d]: got %h want %h", i, got, want);
      end
    end
    vectors++;
    if (bus.irq_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_irq: got %b want 0", bus.irq_o);
    end
    tick(10);
    exp_q.push_back(8'h00);
    rd(3'd1, got);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL midrun_idle: got %h want %h", got, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    bus.R_W_n    = 1'b1;
    bus.timer_cs = 1'b0;
    bus.addr_i   = 16'h0000;
    bus.addr_w_i = 16'h0000;
    bus.data_i   = 8'h00;
    #25 rst_n = 1'b1;
    tick(1);
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_snapshot();
    test_ctrl_collision();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timer_peripheral.md
TIMER_PERIPHERAL -- requirements
Module: timer_peripheral

Interface
REQ-001 Parameter: RESET_PRESCALE, 8'd49, reset value of the PRESCALE register (tick divider).
REQ-002 clk_i  input  1  system clock; one clock.
REQ-003 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 R_W_n  input  1  CPU read/write; 0 = write.
REQ-005 timer_cs  input  1  chip select from the address decoder (IO bank 5, window FE00-FEFF).
REQ-006 addr_i  input  16  current CPU address; bits [2:0] select the write register.
REQ-007 addr_w_i  input  16  registered CPU address; bits [2:0] select the read register.
REQ-008 data_i  input  8  CPU write data.
REQ-009 data_o  output  8  read data; combinational from addr_w_i[2:0] and register state; 8'h00 when timer_cs=0.
REQ-010 irq_o  output  1  interrupt request, active-high, level.

Function
REQ-011 Register map (offset = addr[2:0], mirrored every 8 bytes across the window):
- 0 CTRL (RW): bit0 EN, bit1 AUTO, bit2 IE; bits 7:3 read 0.
- 1 STATUS: bit0 EXP (write 1 clears), bit1 RUN (RO).
- 2 RELOAD_L (RW).
- 3 RELOAD_H (RW).
- 4 SNAP_L (RO, write = snapshot).
- 5 SNAP_H (RO).
- 6 PRESCALE (RW).
- 7 reads 8'h00; writes ignored.
REQ-012 A write occurs on the rising clk_i edge when timer_cs=1 and R_W_n=0; the register is selected by addr_i[2:0].
REQ-013 State machine has two states, IDLE and RUN; RUN reads back as STATUS.bit1.
REQ-014 IDLE->RUN when CTRL.EN is written 0->1: COUNT<=RELOAD, prescaler<=0; the first count decrement occurs PRESCALE+1 clocks later.
REQ-015 Writing EN=1 while in RUN (EN already 1) does not reload the counter or the prescaler.
REQ-016 RUN->IDLE when EN is written 0; COUNT holds its value.
REQ-017 In RUN, the 8-bit prescaler counts 0..PRESCALE and emits a one-clock tick on wrap.
- On each tick with COUNT!=0: COUNT<=COUNT-1.
REQ-018 Tick with COUNT==0 (expiry): EXP<=1 and COUNT<=RELOAD.
- If AUTO=1: stay in RUN; period = (RELOAD+1)*(PRESCALE+1) clocks.
- If AUTO=0: EN<=0 and go to IDLE in the same edge.
REQ-019 RELOAD=0 with AUTO=1 expires on every tick; PRESCALE=0 ticks every clock.
REQ-020 Writing RELOAD or PRESCALE in RUN does not disturb COUNT or the prescaler; the new value applies at the next reload or wrap.
REQ-021 A write to SNAP_L (data ignored) copies the 16-bit COUNT into SNAP in one edge, so SNAP_L/SNAP_H form a coherent pair.
REQ-022 Expiry coincident with a W1C of EXP: set wins, EXP=1.
REQ-023 Expiry coincident with a CTRL write: the CTRL write data wins for EN/AUTO/IE, and EXP is still set.
REQ-024 COUNT is not CPU-writable; all arithmetic wraps modulo 2^16 (COUNT) and 2^8 (prescaler).

Reset
REQ-025 On rst_n_i=0, asynchronously:
- CTRL=0, EXP=0, state=IDLE.
- RELOAD=16'hFFFF, COUNT=0, SNAP=0.
- PRESCALE=RESET_PRESCALE, prescaler=0.
- irq_o=0.
REQ-026 Reset asserted mid-RUN aborts immediately; after release the block remains in IDLE until EN is written 1.

Configuration
REQ-027 Macro TIMER_IRQ_EN defined: irq_o = EXP & CTRL.IE, and CTRL.bit2 is RW.
REQ-028 Macro TIMER_IRQ_EN undefined: irq_o tied 0, CTRL.bit2 reads 0 and ignores writes; EXP polling is unchanged.

Verification
REQ-029 Reset; read all 8 offsets -> 00, 00, FF, FF, 00, 00, RESET_PRESCALE, 00.
REQ-030 Auto-reload with interrupt:
- Stimulus: PRESCALE=0, RELOAD=3, write CTRL=07.
- Response: EXP rises exactly 4 clocks after the CTRL write edge, then every 4 clocks.
- irq_o=1 while EXP=1 (TIMER_IRQ_EN defined).
REQ-031 One-shot:
- Stimulus: PRESCALE=4, RELOAD=2, write CTRL=01.
- Response: EXP set 15 clocks later; CTRL reads 00, RUN=0, COUNT=2; no further expiry.
REQ-032 W1C collision: write STATUS=01 on the exact expiry edge -> EXP reads 1; write STATUS=01 one clock later -> EXP reads 0.
REQ-033 Snapshot coherence:
- Stimulus: PRESCALE=0, RELOAD=16'h0100, write CTRL=01; after 0x81 clocks write SNAP_L.
- Response: SNAP reads 16'h0080 and stays stable while COUNT keeps running.
REQ-034 Reset mid-RUN: assert rst_n_i for 1 clock -> all REQ-029 values, irq_o=0, no expiry after release.
